// File: rtl/ebi_vram_arbiter_if.sv
// Bundles the EBI pins, renderer read port and VRAM port of the VRAM arbiter.
// The slave side is the arbiter. The master side is the MCU/renderer/VRAM environment.
interface ebi_vram_arbiter_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] EBI_AD;
  logic              EBI_ALE;
  logic              EBI_CS;
  logic              EBI_WE;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [LVL_W-1:0]  fifo_level;
  logic              wr_overflow;

  modport slave (
    input  EBI_AD, EBI_ALE, EBI_CS, EBI_WE,
    input  rd_req, rd_addr, mem_rdata,
    output rd_gnt, rd_valid, rd_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output fifo_level, wr_overflow
  );

  modport master (
    output EBI_AD, EBI_ALE, EBI_CS, EBI_WE,
    output rd_req, rd_addr, mem_rdata,
    input  rd_gnt, rd_valid, rd_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  fifo_level, wr_overflow
  );
endinterface

// File: rtl/ebi_vram_arbiter.sv
// Shares a single-port VRAM between the MCU EBI write path and the renderer's
// read port. EBI writes are synchronised, queued in a small FIFO and slotted
// into cycles the renderer leaves idle. A starvation counter forces a write
// through when the renderer has kept the port busy for too long.
module ebi_vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk_100m,
  input  logic               btn_rst,
  ebi_vram_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STARVE_MAX) ? v : v + 1'b1;
  endfunction

  logic              ale_p0, ale_p1, ale_p2;
  logic              cs_p0, cs_p1;
  logic              we_p0, we_p1, we_p2;
  logic [ADDR_W-1:0] ad_p0, ad_p1;
  logic              ale_fall, we_fall;
  logic [ADDR_W-1:0] addr_q;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_idx, rd_idx;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              empty, full, push_ok;
  logic [ENT_W-1:0]  head;

  logic [CNT_W-1:0]  starve_cnt;
  logic              force_w, rd_gnt_p0, wr_go_p0;

  logic              mem_en_p1, mem_we_p1;
  logic [ADDR_W-1:0] mem_addr_p1;
  logic [DATA_W-1:0] mem_wdata_p1;
  logic              vld_p1, vld_p2;

  // ---- EBI synchronisers: stage 1/2 resolve metastability, stage 3 is the edge reference
  always_ff @(posedge clk_100m) begin
    if (btn_rst) begin
      ale_p0 <= 1'b1;
      ale_p1 <= 1'b1;
      ale_p2 <= 1'b1;
      cs_p0  <= 1'b1;
      cs_p1  <= 1'b1;
      we_p0  <= 1'b1;
      we_p1  <= 1'b1;
      we_p2  <= 1'b1;
      ad_p0  <= '0;
      ad_p1  <= '0;
    end else begin
      ale_p0 <= bus.EBI_ALE;
      ale_p1 <= ale_p0;
      ale_p2 <= ale_p1;
      cs_p0  <= bus.EBI_CS;
      cs_p1  <= cs_p0;
      we_p0  <= bus.EBI_WE;
      we_p1  <= we_p0;
      we_p2  <= we_p1;
      ad_p0  <= bus.EBI_AD;
      ad_p1  <= ad_p0;
    end
  end

  // Strobe edges only count while the chip is selected.
  assign ale_fall = ale_p2 & ~ale_p1 & ~cs_p1;
  assign we_fall  = we_p2 & ~we_p1 & ~cs_p1;

  // ---- Address latch: holds the last ALE-captured address for every following write
  always_ff @(posedge clk_100m) begin
    if (btn_rst) begin
      addr_q <= '0;
    end else if (ale_fall) begin
      addr_q <= ad_p1;
    end
  end

  // ---- Write FIFO: a push into a full queue survives only if the head leaves the same cycle
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign push_ok = we_fall && (!full || wr_go_p0);
  assign head    = fifo_mem[rd_idx];

  always_ff @(posedge clk_100m) begin
    if (btn_rst) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (wr_go_p0) begin
        rd_idx <= rd_idx + 1'b1;
      end
      case ({push_ok, wr_go_p0})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (we_fall && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100m) begin
    if (push_ok) begin
      fifo_mem[wr_idx] <= {addr_q, DATA_W'(ad_p1)};
    end
  end

  // ---- Arbitration (cycle N): renderer wins unless a queued write has starved long enough
  always_comb begin
    force_w   = (starve_cnt == STARVE_MAX) && !empty;
    rd_gnt_p0 = bus.rd_req && !force_w;
    wr_go_p0  = !empty && !rd_gnt_p0;
  end

  always_ff @(posedge clk_100m) begin
    if (btn_rst) begin
      starve_cnt <= '0;
    end else if (empty || wr_go_p0) begin
      starve_cnt <= '0;
    end else if (rd_gnt_p0) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // ---- Memory port (cycle N+1) and read-valid return (cycle N+2)
  always_ff @(posedge clk_100m) begin
    if (btn_rst) begin
      mem_en_p1    <= 1'b0;
      mem_we_p1    <= 1'b0;
      mem_addr_p1  <= '0;
      mem_wdata_p1 <= '0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
    end else begin
      mem_en_p1 <= rd_gnt_p0 || wr_go_p0;
      mem_we_p1 <= wr_go_p0;
      vld_p1    <= rd_gnt_p0;
      vld_p2    <= vld_p1;
      if (rd_gnt_p0) begin
        mem_addr_p1 <= bus.rd_addr;
      end else if (wr_go_p0) begin
        mem_addr_p1  <= head[ENT_W-1:DATA_W];
        mem_wdata_p1 <= head[DATA_W-1:0];
      end
    end
  end

  assign bus.rd_gnt      = rd_gnt_p0;
  assign bus.rd_valid    = vld_p2;
  assign bus.rd_data     = bus.mem_rdata;
  assign bus.mem_en      = mem_en_p1;
  assign bus.mem_we      = mem_we_p1;
  assign bus.mem_addr    = mem_addr_p1;
  assign bus.mem_wdata   = mem_wdata_p1;
  assign bus.fifo_level  = level;
  assign bus.wr_overflow = overflow;

endmodule

// File: tb/tb_ebi_vram_arbiter.sv
// Bench for ebi_vram_arbiter: randomized EBI writes and renderer reads, with a
// queue-based reference model predicting every VRAM access and a monitor that
// scores the DUT's memory port and read returns against those predictions.
module tb_ebi_vram_arbiter;
  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk_100m = 1'b0;
  logic btn_rst  = 1'b1;
  always #5 clk_100m = ~clk_100m;

  ebi_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  ebi_vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_100m(clk_100m),
    .btn_rst (btn_rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int rd_pct   = 0;

  // Scoreboard queues: expected write {addr,data}, expected read address, expected read data
  logic [31:0] wq[$];
  logic [15:0] rq_addr[$];
  logic [15:0] rq_data[$];

  // Reference model state
  logic [31:0] mq[$];
  int          scnt    = 0;
  bit          movf    = 1'b0;
  logic [15:0] m_addr  = '0;
  bit          h_ale[3] = '{1'b1, 1'b1, 1'b1};
  bit          h_cs[3]  = '{1'b1, 1'b1, 1'b1};
  bit          h_we[3]  = '{1'b1, 1'b1, 1'b1};
  logic [15:0] h_ad[3]  = '{16'h0, 16'h0, 16'h0};

  function automatic logic [15:0] vram_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100m);
    #2;
  endtask

  task automatic ebi_addr(input logic [15:0] a, input logic cs);
    bus.EBI_CS  = cs;
    bus.EBI_AD  = a;
    bus.EBI_ALE = 1'b0;
    tick(2);
    bus.EBI_ALE = 1'b1;
    tick(1);
  endtask

  task automatic ebi_write(input logic [15:0] d, input logic cs, input int lo, input int hi);
    bus.EBI_CS = cs;
    bus.EBI_AD = d;
    bus.EBI_WE = 1'b0;
    tick(lo);
    bus.EBI_WE = 1'b1;
    tick(hi);
  endtask

  // VRAM: one-cycle read latency, contents are a fixed function of the address
  initial begin
    bit          rd_now;
    logic [15:0] a_now;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk_100m);
      rd_now = bus.mem_en && !bus.mem_we;
      a_now  = bus.mem_addr;
      @(posedge clk_100m);
      #1;
      if (rd_now) bus.mem_rdata = vram_word(a_now);
    end
  end

  // Renderer: holds each request until granted, then picks the next one
  initial begin
    bit g;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    forever begin
      @(negedge clk_100m);
      g = bus.rd_gnt;
      @(posedge clk_100m);
      #2;
      if (!bus.rd_req || g) begin
        bus.rd_req  = ($urandom_range(0, 99) < rd_pct);
        bus.rd_addr = 16'($urandom);
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents a memory access or read data
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk_100m);
      if (bus.mem_en && bus.mem_we) begin
        if (wq.size() == 0) check("unexpected_write", bus.mem_we, 0);
        else begin
          w = wq.pop_front();
          check("wr_addr", bus.mem_addr, w[31:16]);
          check("wr_data", bus.mem_wdata, w[15:0]);
        end
      end else if (bus.mem_en) begin
        if (rq_addr.size() == 0) check("unexpected_read", bus.mem_en, 0);
        else check("rd_mem_addr", bus.mem_addr, rq_addr.pop_front());
      end else begin
        check("we_without_en", bus.mem_we, 0);
      end
      if (bus.rd_valid) begin
        if (rq_data.size() == 0) check("unexpected_rd_valid", bus.rd_valid, 0);
        else check("rd_data", bus.rd_data, rq_data.pop_front());
      end
    end
  end

  // Reference model: one step per cycle from the sampled pins and the arbitration rules
  initial begin
    bit empty, frc, gnt, wgo;
    forever begin
      @(negedge clk_100m);
      #1;
      check("fifo_level", bus.fifo_level, mq.size());
      check("wr_overflow", bus.wr_overflow, movf);
      empty = (mq.size() == 0);
      frc   = (scnt == STARVE_LIMIT) && !empty;
      gnt   = bus.rd_req && !frc;
      wgo   = !empty && !gnt;
      check("rd_gnt", bus.rd_gnt, gnt);
      if (btn_rst) begin
        mq.delete();
        rq_data.delete();
        scnt   = 0;
        movf   = 1'b0;
        m_addr = '0;
        for (int i = 0; i < 3; i++) begin
          h_ale[i] = 1'b1; h_cs[i] = 1'b1; h_we[i] = 1'b1; h_ad[i] = '0;
        end
      end else begin
        if (gnt) begin
          rq_addr.push_back(bus.rd_addr);
          rq_data.push_back(vram_word(bus.rd_addr));
        end
        if (wgo) wq.push_back(mq.pop_front());
        if (empty || wgo) scnt = 0;
        else if (gnt && scnt < STARVE_LIMIT) scnt++;
        if (h_we[2] && !h_we[1] && !h_cs[1]) begin
          if (mq.size() < FIFO_DEPTH) mq.push_back({m_addr, h_ad[1]});
          else movf = 1'b1;
        end
        if (h_ale[2] && !h_ale[1] && !h_cs[1]) m_addr = h_ad[1];
        for (int i = 2; i > 0; i--) begin
          h_ale[i] = h_ale[i-1]; h_cs[i] = h_cs[i-1]; h_we[i] = h_we[i-1]; h_ad[i] = h_ad[i-1];
        end
        h_ale[0] = bus.EBI_ALE;
        h_cs[0]  = bus.EBI_CS;
        h_we[0]  = bus.EBI_WE;
        h_ad[0]  = bus.EBI_AD;
      end
    end
  end

  // Main stimulus
  initial begin
    bus.EBI_AD  = '0;
    bus.EBI_ALE = 1'b1;
    bus.EBI_CS  = 1'b1;
    bus.EBI_WE  = 1'b1;
    tick(3);
    btn_rst = 1'b0;
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_fifo_level", bus.fifo_level, 0);
    check("rst_wr_overflow", bus.wr_overflow, 0);

    // Single write into an idle VRAM
    ebi_addr(16'd5, 1'b0);
    ebi_write(16'd50, 1'b0, 2, 2);
    tick(10);

    // Two writes against a renderer that never lets go
    rd_pct = 100;
    ebi_addr(16'd5, 1'b0);
    ebi_write(16'd50, 1'b0, 2, 2);
    ebi_addr(16'd15, 1'b0);
    ebi_write(16'd30, 1'b0, 2, 2);
    tick(40);

    // Six rapid writes under continuous reads overflow the queue
    ebi_addr(16'h0A00, 1'b0);
    for (int i = 0; i < 6; i++) ebi_write(16'(16'h0B00 + i), 1'b0, 1, 1);
    tick(60);

    // Strobes while deselected must be ignored
    rd_pct = 30;
    ebi_addr(16'h7777, 1'b1);
    ebi_write(16'h1234, 1'b1, 2, 2);
    ebi_write(16'h4321, 1'b0, 2, 2);
    tick(20);

    // Reset with writes queued and reads in flight
    rd_pct = 100;
    ebi_addr(16'h0200, 1'b0);
    for (int i = 0; i < 3; i++) ebi_write(16'(16'h0C00 + i), 1'b0, 1, 1);
    tick(3);
    btn_rst = 1'b1;
    tick(1);
    btn_rst = 1'b0;
    check("post_rst_fifo_level", bus.fifo_level, 0);
    check("post_rst_mem_en", bus.mem_en, 0);
    check("post_rst_rd_valid", bus.rd_valid, 0);
    check("post_rst_wr_overflow", bus.wr_overflow, 0);
    tick(20);

    // Random mix
    for (int it = 0; it < 60; it++) begin
      rd_pct = $urandom_range(0, 100);
      case ($urandom_range(0, 3))
        0: begin
          ebi_addr(16'($urandom), 1'b0);
          ebi_write(16'($urandom), 1'b0, $urandom_range(1, 3), $urandom_range(1, 3));
        end
        1: ebi_write(16'($urandom), 1'b0, $urandom_range(1, 3), $urandom_range(1, 3));
        2: begin
          ebi_addr(16'($urandom), 1'b1);
          ebi_write(16'($urandom), 1'b1, $urandom_range(1, 3), $urandom_range(1, 3));
        end
        default: tick($urandom_range(1, 10));
      endcase
    end

    // Drain and confirm every predicted access appeared
    rd_pct = 0;
    bus.EBI_CS = 1'b1;
    tick(80);
    check("final_writes_pending", wq.size(), 0);
    check("final_reads_pending", rq_addr.size(), 0);
    check("final_rdata_pending", rq_data.size(), 0);
    check("final_fifo_level", bus.fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
